// File: rtl/nbit_down_timer_if.sv
// Control/status bundle for nbit_down_timer: load/enable/mode inputs and
// count/busy/done/zero outputs.
interface nbit_down_timer_if #(
    parameter int BITS = 3
);
    logic            load;
    logic [BITS-1:0] load_val;
    logic            en;
    logic            auto_reload;
    logic [BITS-1:0] count;
    logic            busy;
    logic            done;
    logic            zero;

    modport master (
        output load, load_val, en, auto_reload,
        input  count, busy, done, zero
    );

    modport slave (
        input  load, load_val, en, auto_reload,
        output count, busy, done, zero
    );
endinterface

// File: rtl/nbit_down_timer.sv
// Loadable BITS-wide down timer with one-shot and auto-reload modes.
// Expiry (count reaching 1 while enabled) produces a one-cycle done pulse.
module nbit_down_timer #(
    parameter int BITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    nbit_down_timer_if.slave  tif
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] count_q, count_d;
    logic [BITS-1:0] reload_q, reload_d;
    logic            done_q, done_d;
    logic            busy_q;

    // Next-state: load beats decrement; expiry is count==1 so count never wraps.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (tif.load) begin
            count_d  = tif.load_val;
            reload_d = tif.load_val;
            if (tif.load_val != {BITS{1'b0}}) begin
                state_d = RUN;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (tif.en) begin
                        if (count_q > {{(BITS-1){1'b0}}, 1'b1}) begin
                            count_d = count_q - {{(BITS-1){1'b0}}, 1'b1};
                        end else if (count_q == {{(BITS-1){1'b0}}, 1'b1}) begin
                            done_d = 1'b1;
                            if (tif.auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = {BITS{1'b0}};
                                state_d = IDLE;
                            end
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                IDLE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    count_d = {BITS{1'b0}};
                end
            endcase
        end
    end

    // State, count, reload and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= {BITS{1'b0}};
            reload_q <= {BITS{1'b0}};
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            busy_q   <= (state_d == RUN);
        end
    end

    assign tif.count = count_q;
    assign tif.busy  = busy_q;
    assign tif.done  = done_q;
    assign tif.zero  = (count_q == {BITS{1'b0}});
endmodule

// File: tb/tb_nbit_down_timer.sv
// Directed self-checking bench for nbit_down_timer (BITS=3).
// Each step compares {count, busy, done, zero} against hand-computed values.
module tb_nbit_down_timer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;
    logic [5:0] obs;
    logic [5:0] exp_v;

    nbit_down_timer_if #(.BITS(3)) tif ();

    nbit_down_timer #(.BITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        obs = {tif.count, tif.busy, tif.done, tif.zero};
        exp_v = {3'd0, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL reset_state: got %b want %b", obs, exp_v);
        end
        rst = 1'b0;
        tif.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = {tif.count, tif.busy, tif.done, tif.zero};
            exp_v = {3'd0, 1'b0, 1'b0, 1'b1};
            n_cmp++;
            if (obs !== exp_v) begin
                n_mis++;
                $display("FAIL idle_after_reset[%0d]: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_one_shot;
        tif.load = 1'b1;
        tif.load_val = 3'd5;
        tif.auto_reload = 1'b0;
        tif.en = 1'b1;
        tick();
        tif.load = 1'b0;
        obs = {tif.count, tif.busy, tif.done, tif.zero};
        exp_v = {3'd5, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL one_shot_load: got %b want %b", obs, exp_v);
        end
        for (int i = 4; i >= 0; i--) begin
            tick();
            obs = {tif.count, tif.busy, tif.done, tif.zero};
            exp_v = {3'(i), (i != 0), (i == 0), (i == 0)};
            n_cmp++;
            if (obs !== exp_v) begin
                n_mis++;
                $display("FAIL one_shot_count%0d: got %b want %b", i, obs, exp_v);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            obs = {tif.count, tif.busy, tif.done, tif.zero};
            exp_v = {3'd0, 1'b0, 1'b0, 1'b1};
            n_cmp++;
            if (obs !== exp_v) begin
                n_mis++;
                $display("FAIL one_shot_hold[%0d]: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_auto_reload;
        int seq [6];
        seq = '{2, 1, 3, 2, 1, 3};
        tif.load = 1'b1;
        tif.load_val = 3'd3;
        tif.auto_reload = 1'b1;
        tif.en = 1'b1;
        tick();
        tif.load = 1'b0;
        obs = {tif.count, tif.busy, tif.done, tif.zero};
        exp_v = {3'd3, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL auto_load: got %b want %b", obs, exp_v);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            obs = {tif.count, tif.busy, tif.done, tif.zero};
            exp_v = {3'(seq[i]), 1'b1, (seq[i] == 3), 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_mis++;
                $display("FAIL auto_step%0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_en_gaps;
        int c_exp;
        tif.load = 1'b1;
        tif.load_val = 3'd4;
        tif.auto_reload = 1'b0;
        tif.en = 1'b1;
        tick();
        tif.load = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tif.en = ((c % 2) == 0);
            tick();
            c_exp = 4 - (c / 2);
            obs = {tif.count, tif.busy, tif.done, tif.zero};
            exp_v = {3'(c_exp), (c != 8), (c == 8), (c == 8)};
            n_cmp++;
            if (obs !== exp_v) begin
                n_mis++;
                $display("FAIL en_gap_cycle%0d: got %b want %b", c, obs, exp_v);
            end
        end
        tif.en = 1'b1;
    endtask

    task automatic test_load_priority;
        tif.load = 1'b1;
        tif.load_val = 3'd7;
        tif.auto_reload = 1'b0;
        tif.en = 1'b1;
        tick();
        tif.load = 1'b0;
        tick();
        tick();
        tif.load = 1'b1;
        tif.load_val = 3'd6;
        tick();
        tif.load = 1'b0;
        obs = {tif.count, tif.busy, tif.done, tif.zero};
        exp_v = {3'd6, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL reload_mid_run: got %b want %b", obs, exp_v);
        end
        for (int i = 0; i < 5; i++) tick();
        obs = {tif.count, tif.busy, tif.done, tif.zero};
        exp_v = {3'd1, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL reach_one: got %b want %b", obs, exp_v);
        end
        tif.load = 1'b1;
        tif.load_val = 3'd2;
        tick();
        obs = {tif.count, tif.busy, tif.done, tif.zero};
        exp_v = {3'd2, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL load_at_expiry: got %b want %b", obs, exp_v);
        end
        tif.load_val = 3'd0;
        tick();
        tif.load = 1'b0;
        obs = {tif.count, tif.busy, tif.done, tif.zero};
        exp_v = {3'd0, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL load_zero: got %b want %b", obs, exp_v);
        end
        tick();
        obs = {tif.count, tif.busy, tif.done, tif.zero};
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL load_zero_hold: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid_max;
        tif.load = 1'b1;
        tif.load_val = 3'd7;
        tif.auto_reload = 1'b0;
        tif.en = 1'b1;
        tick();
        tif.load = 1'b0;
        tick();
        tick();
        tick();
        obs = {tif.count, tif.busy, tif.done, tif.zero};
        exp_v = {3'd4, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL max_at_four: got %b want %b", obs, exp_v);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs = {tif.count, tif.busy, tif.done, tif.zero};
        exp_v = {3'd0, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL reset_mid_run: got %b want %b", obs, exp_v);
        end
        tif.load = 1'b1;
        tick();
        tif.load = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            tick();
            obs = {tif.count, tif.busy, tif.done, tif.zero};
            exp_v = {3'(i), (i != 0), (i == 0), (i == 0)};
            n_cmp++;
            if (obs !== exp_v) begin
                n_mis++;
                $display("FAIL max_count%0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back;
        tif.load = 1'b1;
        tif.load_val = 3'd1;
        tif.auto_reload = 1'b1;
        tif.en = 1'b1;
        tick();
        tif.load = 1'b0;
        obs = {tif.count, tif.busy, tif.done, tif.zero};
        exp_v = {3'd1, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL b2b_load: got %b want %b", obs, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = {tif.count, tif.busy, tif.done, tif.zero};
            exp_v = {3'd1, 1'b1, 1'b1, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_mis++;
                $display("FAIL b2b_tick%0d: got %b want %b", i, obs, exp_v);
            end
        end
        tif.auto_reload = 1'b0;
        tick();
        obs = {tif.count, tif.busy, tif.done, tif.zero};
        exp_v = {3'd0, 1'b0, 1'b1, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL b2b_to_one_shot: got %b want %b", obs, exp_v);
        end
        tif.auto_reload = 1'b1;
        tif.load = 1'b1;
        tick();
        tif.load = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs = {tif.count, tif.busy, tif.done, tif.zero};
        exp_v = {3'd0, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL reset_clears_done: got %b want %b", obs, exp_v);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst = 1'b1;
        tif.load = 1'b0;
        tif.load_val = 3'd0;
        tif.en = 1'b0;
        tif.auto_reload = 1'b0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_en_gaps();
        test_load_priority();
        test_reset_mid_max();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
